// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage -- instruction fetch front end.
//
// Holds the fetch PC, issues word-aligned requests to instruction memory over
// a valid/ready channel, and buffers returned words together with their PCs in
// a DEPTH-entry FIFO that is presented to decode over valid/ready. A redirect
// from execute empties the FIFO, restarts fetch at the aligned target and
// discards every response still in flight.
//
// Credit rule: requests are only issued while outstanding + fifo_count < DEPTH,
// so every response that is kept has a free FIFO slot.
//
// Optional feature (macro FETCH_MISALIGN_CHECK_EN):
//   defined   -- a redirect with redirect_pc[1:0] != 0 places one fault entry
//                {redirect_pc, 32'h0000_0013, misaligned=1} in the FIFO and
//                fetch halts until the next redirect or reset.
//   undefined -- the low target bits are masked off and if_misaligned is 0.
//
// Parameters:
//   RESET_PC  first fetch address after reset
//   DEPTH     FIFO entries and maximum in-flight requests (power of two, >= 2)
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   imem_req_valid/ready/addr         request channel to instruction memory
//   imem_resp_valid/data              in-order responses, no backpressure
//   redirect_valid/pc                 branch/jump redirect from execute
//   if_valid/ready, if_pc, if_instr   instruction handshake to decode
//   if_misaligned                     presented entry is a misaligned fault
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_misaligned
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [31:0]   live_pc;           // PC of the oldest request whose data will be kept
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_count;
  logic [CW-1:0] outstanding_next;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic          halted;
  logic          fault_redirect;
  logic [CW:0]   credit_used;
  logic          issue;
  logic          req_fire;
  logic          resp_fire;
  logic          push;
  logic          pop;

  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_pc;
  logic [31:0]   wr_instr;

  // Request side.
  assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign issue          = !reset && !halted && !redirect_valid && (credit_used < DEPTH_W);
  assign imem_req_valid = issue;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = issue && imem_req_ready;

  // A response with nothing outstanding belongs to a stream killed by reset.
  assign resp_fire = imem_resp_valid && (outstanding != '0);

  // Responses in a redirect cycle are discarded along with the FIFO contents.
  assign push = resp_fire && (drop_count == '0) && !redirect_valid;
  assign pop  = if_valid && if_ready;

  assign outstanding_next = outstanding + CW'(req_fire) - CW'(resp_fire);

  // Decode side; outputs read zero whenever nothing is presented.
  assign if_valid = (fifo_count != '0);
  assign if_pc    = if_valid ? pc_mem[rd_ptr]    : '0;
  assign if_instr = if_valid ? instr_mem[rd_ptr] : '0;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign fault_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset)               halted <= 1'b0;
    else if (redirect_valid) halted <= fault_redirect;
  end

  // While halted nothing is fetched and every older response is dropped, so
  // the only entry that can be in the FIFO is the fault entry itself.
  assign if_misaligned = if_valid && halted;
`else
  assign fault_redirect = 1'b0;
  assign halted         = 1'b0;
  assign if_misaligned  = 1'b0;
`endif

  // Single FIFO write port: a live response, or the fault entry at slot 0.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_en    = push;
    wr_idx   = wr_ptr;
    wr_pc    = live_pc;
    wr_instr = imem_resp_data;
    if (fault_redirect) begin
      wr_en    = 1'b1;
      wr_idx   = '0;
      wr_pc    = redirect_pc;
      wr_instr = NOP;
    end
  end

  // NOTE: FIFO storage is not reset; if_valid gates the outputs, so stale
  // contents are never visible and the arrays stay plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_idx]    <= wr_pc;
      instr_mem[wr_idx] <= wr_instr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      live_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      drop_count  <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        fetch_pc   <= {redirect_pc[31:2], 2'b00};
        live_pc    <= {redirect_pc[31:2], 2'b00};
        // Everything still in flight, old drops included, belongs to dead streams.
        drop_count <= outstanding_next;
        rd_ptr     <= '0;
        wr_ptr     <= fault_redirect ? AW'(1) : '0;
        fifo_count <= fault_redirect ? CW'(1) : '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (resp_fire && (drop_count != '0)) drop_count <= drop_count - CW'(1);
        if (push) begin
          live_pc <= live_pc + 32'd4;
          wr_ptr  <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage -- self-checking bench for fetch_stage (DEPTH=4, RESET_PC=0).
//
// An in-order instruction memory model answers accepted requests after a
// fixed or random latency. A stream-level reference checks, every cycle, that
// requests walk consecutive words from the last redirect target, that decode
// receives consecutive PCs from the same target with if_instr equal to memory
// contents, and that no more than DEPTH requests are ever in flight. Directed
// sequences and a vector table cover latency, stalls, redirects and wrap.
// Build with FETCH_MISALIGN_CHECK_EN defined to exercise the fault entry.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data  = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_misaligned;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_misaligned   (if_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Memory contents: multiplication by an odd constant is a bijection, so
  // every word address holds a distinct value.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // ---------------------------------------------------------------------------
  // Instruction memory model: in order, one response per cycle, latency >= 1.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  mreq_t       mq[$];
  int unsigned mcyc     = 0;
  int unsigned mem_lat  = 1;
  bit          lat_rand = 1'b0;

  logic        s_req_fire, s_resp_fire, s_reset, s_lat_rand;
  logic [31:0] s_req_addr;
  int unsigned s_lat;

  always @(negedge clk) begin
    s_req_fire  = imem_req_valid && imem_req_ready;
    s_req_addr  = imem_req_addr;
    s_resp_fire = imem_resp_valid;
    s_reset     = reset;
    s_lat       = mem_lat;
    s_lat_rand  = lat_rand;
  end

  always @(posedge clk) begin
    #1;
    mcyc++;
    if (s_reset) begin
      mq.delete();
    end else begin
      if (s_resp_fire && mq.size() > 0) void'(mq.pop_front());
      if (s_req_fire) begin
        mreq_t r;
        r.addr = s_req_addr;
        r.due  = mcyc - 1 + (s_lat_rand ? $urandom_range(1, 4) : s_lat);
        mq.push_back(r);
      end
    end
    if (mq.size() > 0 && mq[0].due <= mcyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stream-level reference: what addresses and PCs must appear, in order.
  // ---------------------------------------------------------------------------
  logic [31:0] exp_req;
  logic [31:0] exp_pc;
  logic [31:0] mis_pc;
  bit          m_halted;
  bit          mis_pend;

  always @(negedge clk) begin
    if (reset) begin
      exp_req  = RESET_PC;
      exp_pc   = RESET_PC;
      m_halted = 1'b0;
      mis_pend = 1'b0;
    end else begin
      check("inflight_le_depth", 32'(mq.size() <= DEPTH), 32'd1);
      if (imem_req_valid && m_halted) check("req_while_halted", imem_req_valid, 32'd0);
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, exp_req);
        exp_req = exp_req + 32'd4;
      end
      if (if_valid && if_ready) begin
        if (mis_pend) begin
          check("fault_pc", if_pc, mis_pc);
          check("fault_instr", if_instr, NOP);
          check("fault_flag", if_misaligned, 32'd1);
          mis_pend = 1'b0;
        end else if (m_halted) begin
          check("deliver_while_halted", if_valid, 32'd0);
        end else begin
          check("deliver_pc", if_pc, exp_pc);
          check("deliver_instr", if_instr, mem_word(exp_pc));
          check("deliver_flag", if_misaligned, 32'd0);
          exp_pc = exp_pc + 32'd4;
        end
      end
      if (redirect_valid) begin
        exp_req  = {redirect_pc[31:2], 2'b00};
        exp_pc   = {redirect_pc[31:2], 2'b00};
        mis_pend = 1'b0;
        m_halted = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (redirect_pc[1:0] != 2'b00) begin
          mis_pend = 1'b1;
          m_halted = 1'b1;
          mis_pc   = redirect_pc;
        end
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge,
  // outputs are sampled on the falling edge.
  // ---------------------------------------------------------------------------
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) go();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [31:0] target;
    int unsigned lat;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t tbl[7];
  int   n_req;
  int   n_del;
  bit   found;

  initial begin
    tbl[0] = '{32'h0000_0100, 1, 32'h0000_0100, 1'b0};
    tbl[1] = '{32'h0000_0FFC, 2, 32'h0000_0FFC, 1'b0};
    tbl[2] = '{32'hFFFF_FFF8, 1, 32'hFFFF_FFF8, 1'b0};
`ifdef FETCH_MISALIGN_CHECK_EN
    tbl[3] = '{32'h0000_0102, 1, 32'h0000_0102, 1'b1};
    tbl[4] = '{32'h0000_0200, 1, 32'h0000_0200, 1'b0};
    tbl[5] = '{32'h0000_0007, 3, 32'h0000_0007, 1'b1};
`else
    tbl[3] = '{32'h0000_0102, 1, 32'h0000_0100, 1'b0};
    tbl[4] = '{32'h0000_0200, 1, 32'h0000_0200, 1'b0};
    tbl[5] = '{32'h0000_0007, 3, 32'h0000_0004, 1'b0};
`endif
    tbl[6] = '{32'h0000_0040, 2, 32'h0000_0040, 1'b0};

    reset          = 1'b1;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_lat        = 1;

    // Reset state.
    repeat (3) go();
    look();
    check("rst_req_valid", imem_req_valid, 32'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_if_valid", if_valid, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_if_misaligned", if_misaligned, 32'd0);
    go();
    reset = 1'b0;

    // Streaming from reset with 1-cycle memory: first data at cycle 2, then one per cycle.
    look();
    check("c0_req_valid", imem_req_valid, 32'd1);
    check("c0_req_addr", imem_req_addr, RESET_PC);
    check("c0_if_valid", if_valid, 32'd0);
    go();
    look();
    check("c1_req_addr", imem_req_addr, RESET_PC + 32'd4);
    check("c1_if_valid", if_valid, 32'd0);
    go();
    look();
    check("c2_if_valid", if_valid, 32'd1);
    check("c2_if_pc", if_pc, RESET_PC);
    for (int k = 1; k <= 10; k++) begin
      go();
      look();
      check("stream_if_valid", if_valid, 32'd1);
      check("stream_if_pc", if_pc, RESET_PC + 32'(4 * k));
    end
    go();

    // Decode stalled for 10 cycles: exactly DEPTH requests, head stays at 0x0.
    if_ready = 1'b0;
    apply_reset();
    n_req = 0;
    for (int i = 0; i < 10; i++) begin
      look();
      if (imem_req_valid && imem_req_ready) n_req++;
      if (if_valid) check("stall_if_pc", if_pc, RESET_PC);
      go();
    end
    check("stall_req_count", n_req, DEPTH);
    if_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      look();
      check("drain_if_valid", if_valid, 32'd1);
      check("drain_if_pc", if_pc, RESET_PC + 32'(4 * k));
      go();
    end

    // 3-cycle memory, two requests in flight, redirect to 0x100.
    mem_lat = 3;
    apply_reset();
    go();
    go();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    look();
    check("redir_cycle_no_req", imem_req_valid, 32'd0);
    go();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    look();
    check("redir_next_req_valid", imem_req_valid, 32'd1);
    check("redir_next_req_addr", imem_req_addr, 32'h0000_0100);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      go();
      look();
      if (if_valid) found = 1'b1;
    end
    check("late_drop_found", found, 32'd1);
    check("late_drop_if_pc", if_pc, 32'h0000_0100);
    check("late_drop_if_instr", if_instr, mem_word(32'h0000_0100));
    go();

    // Redirect coinciding with an if handshake and a response (1-cycle memory).
    mem_lat = 1;
    apply_reset();
    repeat (6) go();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0340;
    look();
    check("coinc_if_valid_R", if_valid, 32'd1);
    go();
    redirect_valid = 1'b0;
    look();
    check("coinc_if_valid_R1", if_valid, 32'd0);
    check("coinc_req_valid_R1", imem_req_valid, 32'd1);
    check("coinc_req_addr_R1", imem_req_addr, 32'h0000_0340);
    go();
    look();
    check("coinc_if_valid_R2", if_valid, 32'd0);
    go();
    look();
    check("coinc_if_valid_R3", if_valid, 32'd1);
    check("coinc_if_pc_R3", if_pc, 32'h0000_0340);
    go();

    // imem_req_ready toggling, 2-cycle memory; the reference checks every address.
    mem_lat = 2;
    n_del   = 0;
    for (int c = 0; c < 40; c++) begin
      imem_req_ready = c[0];
      look();
      if (if_valid && if_ready) n_del++;
      go();
    end
    imem_req_ready = 1'b1;
    check("toggle_progress", 32'(n_del >= 10), 32'd1);

    // Redirect vector table.
    for (int i = 0; i < 7; i++) begin
      mem_lat = tbl[i].lat;
      repeat (6) go();
      redirect_valid = 1'b1;
      redirect_pc    = tbl[i].target;
      look();
      go();
      redirect_valid = 1'b0;
      look();
      found = if_valid;
      for (int j = 0; j < 20 && !found; j++) begin
        go();
        look();
        if (if_valid) found = 1'b1;
      end
      check("tbl_found", found, 32'd1);
      check("tbl_if_pc", if_pc, tbl[i].exp_pc);
      check("tbl_if_misaligned", if_misaligned, tbl[i].exp_mis);
      check("tbl_if_instr", if_instr, tbl[i].exp_mis ? NOP : mem_word(tbl[i].exp_pc));
`ifdef FETCH_MISALIGN_CHECK_EN
      if (tbl[i].exp_mis) begin
        for (int j = 0; j < 8; j++) begin
          go();
          look();
          check("halt_no_req", imem_req_valid, 32'd0);
        end
      end
`endif
      go();
    end

    // Random traffic: random latency, backpressure, redirects and resets.
    lat_rand = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      imem_req_ready = ($urandom_range(0, 9) < 7);
      if_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = $urandom;
      if ($urandom_range(0, 1) == 0) redirect_pc[1:0] = 2'b00;
      if ($urandom_range(0, 399) == 0) begin
        redirect_valid = 1'b0;
        apply_reset();
      end else begin
        go();
      end
    end
    redirect_valid = 1'b0;
    repeat (5) go();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch front end of the RISC-V CPU. Holds the PC, issues word-aligned requests to instruction memory over a valid/ready channel, and buffers returned instructions with their PCs in a small FIFO. It hands them to decode over a valid/ready handshake. Branch and jump redirects from execute flush the FIFO and discard in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, FIFO entries and max in-flight requests; power of two, ≥2

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- imem_req_valid  out  1  request address valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address, bits [1:0] always 0
- imem_resp_valid  in  1  response valid; in order, ≥1 cycle after acceptance, no backpressure
- imem_resp_data  in  32  instruction word
- redirect_valid  in  1  redirect the PC this cycle
- redirect_pc  in  32  redirect target
- if_valid  out  1  if_pc/if_instr valid to decode
- if_ready  in  1  decode accepts
- if_pc  out  32  PC of presented instruction
- if_instr  out  32  presented instruction
- if_misaligned  out  1  presented entry is a misaligned-target fault (see Configuration)

## Operation
- State: fetch_pc, FIFO (pc, instr, misaligned) of DEPTH entries, outstanding count, drop count. Both counts are $clog2(DEPTH)+1 bits wide.
- Issue condition: outstanding + fifo_count < DEPTH, drop_count == 0 not required, not halted, and redirect_valid == 0.
- imem_req_valid = issue condition. imem_req_addr = fetch_pc.
- Request acceptance (valid & ready): fetch_pc += 4, wrapping mod 2^32, and outstanding += 1.
- Response:
  - outstanding -= 1.
  - If drop_count > 0: drop_count -= 1 and the data is discarded.
  - Otherwise push {pc of oldest live request, data, 0}. PCs of live requests are tracked in a PC queue, or derived as head PC + 4·k.
- Enqueue never overflows, by the credit rule.
- Dequeue: if_valid & if_ready pops the head. Enqueue and dequeue in the same cycle are both allowed, including when full or empty.
- if_valid = fifo_count != 0. No response-to-output bypass.
- Redirect cycle:
  - FIFO is emptied.
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - drop_count ← outstanding after this cycle's response decrement (the response in the redirect cycle, if any, is discarded).
  - An if handshake in the same cycle counts as consumed. Redirect then wins and all entries, including the new one, are flushed.
- Redirect while drop_count > 0: the new drop_count = total outstanding. Nothing from older streams survives.
- Reset mid-operation: all state cleared. Responses arriving after reset are not counted. The memory side must also be reset.

## Timing
- Reset values: imem_req_valid 0 while reset is high; imem_req_addr = RESET_PC; if_valid 0; if_pc 0; if_instr 0; if_misaligned 0; all counts 0.
- First request: imem_req_valid = 1 in the first cycle after reset deasserts, addr = RESET_PC.
- Latency: response captured at edge t gives if_valid = 1 in cycle t+1. With 1-cycle memory, request cycle N → if_valid at N+2.
- Throughput: 1 instruction/cycle with 1-cycle memory and if_ready held 1.
- Redirect in cycle R: first new-PC request in R+1, earliest if_valid in R+3.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 flushes as normal and enqueues one entry {redirect_pc, 32'h0000_0013, 1} in cycle R+1.
  - Fetch then halts (no requests) until the next redirect or reset.
- Undefined:
  - Low bits are silently masked to 0 and fetch continues.
  - if_misaligned is tied 0.

## Test plan
- Reset then 1-cycle memory, if_ready=1: requests 0x0, 0x4, 0x8… on consecutive cycles. if_pc 0x0 at cycle 2 after reset release, then +4 every cycle.
- if_ready=0 for 10 cycles: at most DEPTH=4 requests issued. if_valid holds with if_pc=0x0 stable. On release, 0x0–0xC drain on back-to-back cycles.
- 3-cycle memory with 2 requests in flight, redirect to 0x100: both late responses dropped. Next if_pc is 0x100 and the FIFO was emptied.
- Redirect coinciding with an if handshake and a response: no stale entry appears. Next if_pc = target.
- imem_req_ready toggling 0/1: addresses never skip or repeat. if_instr matches memory for each if_pc.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102: one entry if_pc=0x102, if_misaligned=1, if_instr=0x13. No requests follow until a redirect to 0x200 resumes fetch.
